// File: rtl/shape_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shape_cmd_sequencer_if
// Purpose  : Bundles the command, SFR and response signals of the shape
//            command sequencer. The slave modport is the sequencer side; the
//            master modport is its environment (command source, shape
//            processor SFR port and response sink).
// Revision : 1.0 - initial release
// ============================================================================
interface shape_cmd_sequencer_if;
  // Command stream from the upstream source
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_shape;
  logic [4:0]  cmd_operation;
  // SFR port towards the shape processor
  logic        write;
  logic [31:0] write_data;
  logic        read;
  logic [31:0] read_data;
  // Result stream and debug counters
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_accepted;
  logic [1:0]  rsp_shape;
  logic [4:0]  rsp_operation;
  logic [15:0] accepted_count;
  logic [15:0] rejected_count;

  modport slave (
    input  cmd_valid, cmd_shape, cmd_operation, read_data, rsp_ready,
    output cmd_ready, write, write_data, read, rsp_valid, rsp_accepted,
           rsp_shape, rsp_operation, accepted_count, rejected_count
  );

  modport master (
    output cmd_valid, cmd_shape, cmd_operation, read_data, rsp_ready,
    input  cmd_ready, write, write_data, read, rsp_valid, rsp_accepted,
           rsp_shape, rsp_operation, accepted_count, rejected_count
  );
endinterface
`default_nettype wire

// File: rtl/shape_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shape_cmd_sequencer
// Purpose  : Queues {shape, operation} commands, writes each one into the
//            shape processor control register, reads it back and reports
//            whether the processor kept the value. Saturating accept/reject
//            counters are kept for debug.
// Revision : 1.0 - initial release
// ============================================================================
module shape_cmd_sequencer #(
  parameter int DEPTH        = 4,   // command FIFO entries, power of two
  parameter int READ_LATENCY = 1    // read pulse to valid read_data, 0..3
) (
  input  logic                  clk,
  input  logic                  rst,
  shape_cmd_sequencer_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [1:0]  WAIT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam bit          NO_WAIT    = (READ_LATENCY == 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [2:0]    state;
  logic [1:0]    wait_cnt;
  logic [1:0]    cmd_shape_q;
  logic [4:0]    cmd_op_q;

  // Ready depends only on the occupancy register, never on this cycle's pop
  assign full          = (count == FULL_COUNT);
  assign empty         = (count == '0);
  assign push          = bus.cmd_valid && !full;
  assign pop           = (state == S_IDLE) && !empty;
  assign bus.cmd_ready = !full;

  // Storage array, written on every accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_shape, bus.cmd_operation};
    end
  end

  // Pointers and occupancy; reset flushes the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing: one command in flight, write then read back
  // --------------------------------------------------------------------------
  logic [1:0] rd_shape;
  logic [4:0] rd_op;
  logic       sample;
  logic       accept;
  logic       unused_read_bits;

  assign rd_shape = bus.read_data[17:16];
  assign rd_op    = bus.read_data[4:0];
  assign unused_read_bits = ^{bus.read_data[31:18], bus.read_data[15:5]};

  // Readback is captured in READ when there is no latency, else on the last WAIT cycle
  assign sample = ((state == S_READ) && NO_WAIT) ||
                  ((state == S_WAIT) && (wait_cnt == WAIT_LAST));

  // Shape must be one-hot so a shape-0 command cannot match the register's reset value
  assign accept = (rd_shape == cmd_shape_q) && (rd_op == cmd_op_q) &&
                  ((cmd_shape_q == 2'b01) || (cmd_shape_q == 2'b10));

  // FSM: IDLE -> WRITE -> READ -> (WAIT) -> RESP -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      cmd_shape_q <= '0;
      cmd_op_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            {cmd_shape_q, cmd_op_q} <= mem[rd_ptr];
            state <= S_WRITE;
          end
        end
        S_WRITE: state <= S_READ;
        S_READ: begin
          wait_cnt <= '0;
          state    <= NO_WAIT ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_RESP;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.write      = (state == S_WRITE);
  assign bus.write_data = bus.write ? {14'b0, cmd_shape_q, 11'b0, cmd_op_q} : 32'b0;
  assign bus.read       = (state == S_READ);
  assign bus.rsp_valid  = (state == S_RESP);

  // --------------------------------------------------------------------------
  // Response fields and debug counters, updated once per command on sampling
  // --------------------------------------------------------------------------
  logic [1:0]  rsp_shape_q;
  logic [4:0]  rsp_op_q;
  logic        rsp_acc_q;
  logic [15:0] acc_cnt;
  logic [15:0] rej_cnt;

  // Capture readback and verdict; held stable through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_shape_q <= '0;
      rsp_op_q    <= '0;
      rsp_acc_q   <= 1'b0;
    end else if (sample) begin
      rsp_shape_q <= rd_shape;
      rsp_op_q    <= rd_op;
      rsp_acc_q   <= accept;
    end
  end

  // Saturating accept/reject counters
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
    end else if (sample) begin
      if (accept) begin
        if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      end else begin
        if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
      end
    end
  end

  assign bus.rsp_shape      = rsp_shape_q;
  assign bus.rsp_operation  = rsp_op_q;
  assign bus.rsp_accepted   = rsp_acc_q;
  assign bus.accepted_count = acc_cnt;
  assign bus.rejected_count = rej_cnt;

endmodule
`default_nettype wire
